// File: rtl/adder_digit_serial.sv
// adder_digit_serial: N-bit adder/subtractor that ripples W bits per cycle,
// with valid/ready handshakes on the operand and result sides.
module adder_digit_serial #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    localparam int ND = N / W;
    localparam int KW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(ND - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  sum_q;
    logic          carry_q;
    logic          c_out_q;
    logic          ovf_q;
    logic [KW-1:0] k_q;

    logic [W-1:0]  a_dig;
    logic [W-1:0]  b_dig;
    logic [W:0]    dsum_d;
    logic          msb_cin_d;
    logic [N-1:0]  sum_d;

    // b_q already holds the inverted operand for subtraction
    always_comb begin
        a_dig     = a_q[int'(k_q)*W +: W];
        b_dig     = b_q[int'(k_q)*W +: W];
        dsum_d    = {1'b0, a_dig} + {1'b0, b_dig} + {{W{1'b0}}, carry_q};
        msb_cin_d = dsum_d[W-1] ^ a_dig[W-1] ^ b_dig[W-1];
        sum_d     = sum_q;
        sum_d[int'(k_q)*W +: W] = dsum_d[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= c_in ^ sub;
                        k_q     <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q   <= sum_d;
                    carry_q <= dsum_d[W];
                    if (k_q == K_LAST) begin
                        c_out_q <= dsum_d[W];
                        ovf_q   <= msb_cin_d ^ dsum_d[W];
                        k_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_digit_serial.sv
// Bench for adder_digit_serial: directed N=8/W=4 vectors and corner
// sequences, plus random N=32 traffic for W = 1, 8 and 32.
module tb_adder_digit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // N=8, W=4 instance
    logic       rst8, iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, sum8;

    adder_digit_serial #(.N(8), .W(4)) u8 (
        .clk(clk), .rst(rst8), .i_valid(iv8), .i_ready(ir8),
        .a(a8), .b(b8), .c_in(cin8), .sub(sub8),
        .o_valid(ov8), .o_ready(or8), .sum(sum8),
        .c_out(co8), .overflow(of8)
    );

    // N=32 instances, W = 1, 8, 32
    logic            rst32;
    logic [2:0]      riv, rir, rcin, rsub, rov, ror, rco, rof;
    logic [2:0][31:0] ra, rb, rsum;

    for (genvar g = 0; g < 3; g++) begin : g_r
        localparam int WW = (g == 0) ? 1 : (g == 1) ? 8 : 32;
        adder_digit_serial #(.N(32), .W(WW)) u (
            .clk(clk), .rst(rst32), .i_valid(riv[g]), .i_ready(rir[g]),
            .a(ra[g]), .b(rb[g]), .c_in(rcin[g]), .sub(rsub[g]),
            .o_valid(rov[g]), .o_ready(ror[g]), .sum(rsum[g]),
            .c_out(rco[g]), .overflow(rof[g])
        );
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts,
                       output logic [7:0] rs, output logic rc,
                       output logic ro, output int lat);
        int guard;
        guard = 0;
        while (!ir8 && guard < 20) begin
            tick();
            guard++;
        end
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        rs = sum8; rc = co8; ro = of8;
    endtask

    task automatic rel8();
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_rand(input int g, input int nops);
        int wd;
        int elat;
        wd   = (g == 0) ? 1 : (g == 1) ? 8 : 32;
        elat = 32 / wd;
        for (int n = 0; n < nops; n++) begin
            logic [31:0] ta, tb, be;
            logic        tc, ts, eo;
            logic [32:0] full;
            longint      sx;
            int          lat, guard;
            ta = pick(); tb = pick();
            tc = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            be   = ts ? ~tb : tb;
            full = {1'b0, ta} + {1'b0, be} + 33'(tc ^ ts);
            sx   = longint'($signed(ta)) + longint'($signed(be))
                 + longint'(tc ^ ts);
            eo   = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
            guard = 0;
            while (!rir[g] && guard < 8) begin
                tick();
                guard++;
            end
            if (!rir[g]) check("rnd_ready_timeout", 64'(rir[g]), 64'd1);
            ra[g] = ta; rb[g] = tb; rcin[g] = tc; rsub[g] = ts;
            riv[g] = 1'b1;
            tick();
            riv[g] = 1'b0;
            ra[g] = $urandom; rb[g] = $urandom;
            lat = 0;
            while (!rov[g] && lat < 40) begin
                ror[g] = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            ror[g] = 1'b0;
            check("rnd_lat", 64'(lat), 64'(elat));
            check("rnd_sum", 64'(rsum[g]), 64'(full[31:0]));
            check("rnd_cout", 64'(rco[g]), 64'(full[32]));
            check("rnd_ovf", 64'(rof[g]), 64'(eo));
            repeat ($urandom_range(0, 2)) tick();
            ror[g] = 1'b1;
            tick();
            ror[g] = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rs;
        logic       rc, ro;
        int         lat;

        vt[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{8'h7F, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[6] = '{8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
        vt[7] = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0};

        rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        rst32 = 1'b1; riv = '0; ror = '0; rcin = '0; rsub = '0;
        ra = '0; rb = '0;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0; rst32 = 1'b0;

        check("rst_iready", 64'(ir8), 64'd1);
        check("rst_ovalid", 64'(ov8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_cout", 64'(co8), 64'd0);
        check("rst_ovf", 64'(of8), 64'd0);

        for (int i = 0; i < 8; i++) begin
            op8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vt[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vt[i].co));
            check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vt[i].ov));
            rel8();
            check($sformatf("vec%0d_idle", i), 64'(ir8), 64'd1);
        end

        // result held while consumer stalls; new operands ignored
        op8(8'h12, 8'h34, 1'b0, 1'b0, rs, rc, ro, lat);
        check("hold_first", 64'(rs), 64'h46);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; iv8 = 1'b1;
            tick();
            check("hold_sum", 64'(sum8), 64'h46);
            check("hold_iready", 64'(ir8), 64'd0);
            check("hold_ovalid", 64'(ov8), 64'd1);
        end
        iv8 = 1'b0;
        rel8();
        check("hold_rel_iready", 64'(ir8), 64'd1);
        check("hold_rel_ovalid", 64'(ov8), 64'd0);
        check("hold_rel_sum", 64'(sum8), 64'h46);

        // abort in the second BUSY cycle
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        rst8 = 1'b1;
        or8 = 1'b1;
        tick();
        rst8 = 1'b0;
        or8 = 1'b0;
        check("abort_iready", 64'(ir8), 64'd1);
        check("abort_ovalid", 64'(ov8), 64'd0);
        check("abort_sum", 64'(sum8), 64'd0);
        repeat (3) tick();
        check("abort_no_result", 64'(ov8), 64'd0);
        op8(8'h02, 8'h02, 1'b1, 1'b0, rs, rc, ro, lat);
        check("after_abort_sum", 64'(rs), 64'h05);
        check("after_abort_lat", 64'(lat), 64'd2);
        rel8();

        for (int g = 0; g < 3; g++) run_rand(g, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
